fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multicycle control FSM.
- Holds the program counter and instruction register, and fetches from instruction memory over a req/valid handshake.
- Presents OPCODE/MM fields to the controller and applies the controller's PC_WRITE/PC_SEL/PC_RST/BR_SEL commands.
- Latches a halt flag when an HLT instruction is captured.

Parameters:
PC_W, 16, program counter / instruction address width
IR_W, 32, instruction width
RESET_PC, 0, PC value after RST or PC_RST

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
FETCH_EN  in  1  one-cycle pulse from controller fetch state; starts a fetch
PC_WRITE  in  1  update PC this cycle
PC_SEL  in  1  0: PC+1, 1: branch target
BR_SEL  in  1  0: absolute target, 1: PC-relative target
PC_RST  in  1  synchronous PC clear to RESET_PC
IMEM_REQ  out  1  read request, held until IMEM_VALID
IMEM_ADDR  out  PC_W  read address
IMEM_VALID  in  1  read data valid, one cycle
IMEM_RDATA  in  IR_W  read data
IR  out  IR_W  instruction register
OPCODE  out  4  IR[31:28]
MM  out  4  IR[27:24] (addressing mode; 8 = immediate)
PC  out  PC_W  current program counter
IR_VALID  out  1  one-cycle pulse on the cycle after IR is loaded
BUSY  out  1  fetch in progress
HALTED  out  1  sticky; set when a captured opcode is 15

Behaviour:
- Reset (RST=1, asynchronous): state IDLE, PC=RESET_PC, IR=0 (noop), IMEM_REQ=0, IMEM_ADDR=RESET_PC, IR_VALID=0, BUSY=0, HALTED=0.
- FSM states:
  - IDLE:
    - On FETCH_EN=1 and HALTED=0: latch IMEM_ADDR<=PC, go to WAIT.
    - FETCH_EN while HALTED is ignored.
  - WAIT:
    - IMEM_REQ=1, BUSY=1.
    - On IMEM_VALID=1: IR<=IMEM_RDATA, go to DONE.
    - If IMEM_RDATA[31:28]==15, HALTED<=1 on the same edge.
    - Stays in WAIT with no limit until IMEM_VALID.
  - DONE: IR_VALID=1, BUSY=0, IMEM_REQ=0; next state IDLE unconditionally.
- Fetch latency:
  - FETCH_EN at cycle n gives IMEM_REQ high from n+1.
  - IMEM_VALID at cycle m gives IR updated at the m edge and IR_VALID high during m+1.
  - Minimum FETCH_EN-to-IR_VALID latency: 2 cycles.
- FETCH_EN while in WAIT or DONE is ignored; it is not queued.
- IMEM_VALID in IDLE or DONE is ignored and IR is unchanged.
- IMEM_ADDR is stable for the whole request. A PC change mid-fetch does not alter the in-flight address.
- PC update is evaluated every cycle regardless of FSM state. Priority:
  - PC_RST: PC<=RESET_PC.
  - else PC_WRITE & !PC_SEL: PC<=PC+1.
  - else PC_WRITE & PC_SEL & !BR_SEL: PC<=IR[PC_W-1:0].
  - else PC_WRITE & PC_SEL & BR_SEL: PC<=PC + sign_extend(IR[15:0]).
- Arithmetic is modulo 2^PC_W: PC=0xFFFF increments to 0x0000, and relative branches wrap.
- Relative offset is applied to the PC value present in the cycle PC_WRITE is sampled.
- OPCODE and MM are combinational slices of IR, so they are 0 after reset.
- HALTED is cleared only by RST; PC_RST does not clear it.
- RST asserted mid-fetch aborts the fetch. An IMEM_VALID arriving after reset release is ignored because the FSM is in IDLE.

Decomposition:
- Shared package (cpu_pkg):
  - Opcode constants: noop=0, lod=1, str=2, bra=4, brr=5, bne=6, alu_op=8, hlt=15.
  - Addressing-mode constant am_imm=8.
  - IR field positions: OPCODE 31:28, MM 27:24, IMM 15:0.
  - Fetch FSM state encoding IDLE/WAIT/DONE.
  - Shared with the control FSM.
- One sub-module, next_pc: purely combinational PC+1 / absolute / relative mux-and-adder. The PC register stays in fetch_unit.

Test Plan:
- Reset, then FETCH_EN with IMEM_VALID on the next cycle and RDATA=0x8000_0003 -> IMEM_ADDR=0x0000, OPCODE=8, MM=0, IR_VALID one-cycle pulse, BUSY low afterward.
- FETCH_EN with IMEM_VALID delayed 5 cycles -> IMEM_REQ high and IMEM_ADDR constant for all 5 cycles; FETCH_EN pulses during WAIT are ignored (exactly one IR_VALID).
- PC=0x0010 with IR imm=0xFFFC, PC_WRITE=1, PC_SEL=1, BR_SEL=1 -> PC=0x000C; same with BR_SEL=0 -> PC=0xFFFC; PC=0xFFFF with PC_WRITE=1, PC_SEL=0 -> PC=0x0000.
- PC_RST=1 and PC_WRITE=1 in the same cycle -> PC=RESET_PC; PC_WRITE during WAIT -> IMEM_ADDR unchanged, PC updated.
- Fetch RDATA=0xF000_0000 -> HALTED=1, OPCODE=15; later FETCH_EN -> no IMEM_REQ; PC_RST -> HALTED stays 1; RST -> HALTED=0.
- RST pulsed during WAIT, IMEM_VALID arriving 2 cycles after release -> IR stays 0, no IR_VALID, state IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and the multicycle control FSM:
// opcodes, addressing modes, instruction field positions and fetch states.
package cpu_pkg;

  localparam logic [3:0] OP_NOOP   = 4'd0;
  localparam logic [3:0] OP_LOD    = 4'd1;
  localparam logic [3:0] OP_STR    = 4'd2;
  localparam logic [3:0] OP_BRA    = 4'd4;
  localparam logic [3:0] OP_BRR    = 4'd5;
  localparam logic [3:0] OP_BNE    = 4'd6;
  localparam logic [3:0] OP_ALU_OP = 4'd8;
  localparam logic [3:0] OP_HLT    = 4'd15;

  localparam logic [3:0] AM_IMM = 4'd8;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 28;
  localparam int MM_HI     = 27;
  localparam int MM_LO     = 24;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int IMM_W     = IMM_HI - IMM_LO + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection: sequential increment, absolute target,
// or PC-relative target with a sign-extended 16-bit offset (all modulo 2^PC_W).
module next_pc
  import cpu_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  abs_target,
  input  logic [IMM_W-1:0] imm,
  input  logic             pc_sel,
  input  logic             br_sel,
  output logic [PC_W-1:0]  npc
);

  logic [PC_W-1:0] offset;

  always_comb begin
    offset = PC_W'($signed(imm));
    npc    = pc + PC_W'(1);
    if (pc_sel) begin
      npc = br_sel ? (pc + offset) : abs_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC and IR registers, req/valid instruction memory
// handshake, and a sticky halt flag raised when an HLT instruction is captured.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          PC_W     = 16,
  parameter int          IR_W     = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FETCH_EN,
  input  logic            PC_WRITE,
  input  logic            PC_SEL,
  input  logic            BR_SEL,
  input  logic            PC_RST,
  output logic            IMEM_REQ,
  output logic [PC_W-1:0] IMEM_ADDR,
  input  logic            IMEM_VALID,
  input  logic [IR_W-1:0] IMEM_RDATA,
  output logic [IR_W-1:0] IR,
  output logic [3:0]      OPCODE,
  output logic [3:0]      MM,
  output logic [PC_W-1:0] PC,
  output logic            IR_VALID,
  output logic            BUSY,
  output logic            HALTED
);

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

  fetch_state_t    state, state_d;
  logic [PC_W-1:0] pc_next;
  logic            start_fetch;
  logic            capture;

  assign OPCODE      = IR[OPCODE_HI:OPCODE_LO];
  assign MM          = IR[MM_HI:MM_LO];
  assign start_fetch = (state == IDLE) && FETCH_EN && !HALTED;
  assign capture     = (state == WAIT) && IMEM_VALID;

  next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc         (PC),
    .abs_target (IR[PC_W-1:0]),
    .imm        (IR[IMM_HI:IMM_LO]),
    .pc_sel     (PC_SEL),
    .br_sel     (BR_SEL),
    .npc        (pc_next)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    IMEM_REQ = 1'b0;
    BUSY     = 1'b0;
    IR_VALID = 1'b0;
    case (state)
      IDLE: if (start_fetch) state_d = WAIT;
      WAIT: begin
        IMEM_REQ = 1'b1;
        BUSY     = 1'b1;
        if (IMEM_VALID) state_d = DONE;
      end
      DONE: begin
        IR_VALID = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address is captured once at fetch start so later PC updates cannot disturb the request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IMEM_ADDR <= RESET_PC_V;
      IR        <= '0;
      HALTED    <= 1'b0;
    end else begin
      if (start_fetch) IMEM_ADDR <= PC;
      if (capture) begin
        IR <= IMEM_RDATA;
        if (IMEM_RDATA[OPCODE_HI:OPCODE_LO] == OP_HLT) HALTED <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           PC <= RESET_PC_V;
    else if (PC_RST)   PC <= RESET_PC_V;
    else if (PC_WRITE) PC <= pc_next;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: handshake timing, PC update
// priority and wrap, halt behaviour and reset abort of an in-flight fetch.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FETCH_EN, PC_WRITE, PC_SEL, BR_SEL, PC_RST;
  logic        IMEM_REQ, IMEM_VALID;
  logic [15:0] IMEM_ADDR, PC;
  logic [31:0] IMEM_RDATA, IR;
  logic [3:0]  OPCODE, MM;
  logic        IR_VALID, BUSY, HALTED;

  int checks = 0;
  int errors = 0;
  int pulses;

  fetch_unit #(.PC_W(16), .IR_W(32), .RESET_PC(0)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FETCH_EN   (FETCH_EN),
    .PC_WRITE   (PC_WRITE),
    .PC_SEL     (PC_SEL),
    .BR_SEL     (BR_SEL),
    .PC_RST     (PC_RST),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_VALID (IMEM_VALID),
    .IMEM_RDATA (IMEM_RDATA),
    .IR         (IR),
    .OPCODE     (OPCODE),
    .MM         (MM),
    .PC         (PC),
    .IR_VALID   (IR_VALID),
    .BUSY       (BUSY),
    .HALTED     (HALTED)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; FETCH_EN = 0; PC_WRITE = 0; PC_SEL = 0; BR_SEL = 0; PC_RST = 0;
    IMEM_VALID = 0; IMEM_RDATA = '0;
    tick(); tick();
    check_output("rst_pc", 32'(PC), 32'h0);
    check_output("rst_ir", IR, 32'h0);
    check_output("rst_req", 32'(IMEM_REQ), 32'h0);
    check_output("rst_addr", 32'(IMEM_ADDR), 32'h0);
    check_output("rst_irvalid", 32'(IR_VALID), 32'h0);
    check_output("rst_busy", 32'(BUSY), 32'h0);
    check_output("rst_halted", 32'(HALTED), 32'h0);
    check_output("rst_opcode", 32'(OPCODE), 32'h0);
    RST = 1'b0;
    tick();

    // Minimum-latency fetch
    FETCH_EN = 1; tick(); FETCH_EN = 0;
    check_output("f1_req", 32'(IMEM_REQ), 32'h1);
    check_output("f1_busy", 32'(BUSY), 32'h1);
    check_output("f1_addr", 32'(IMEM_ADDR), 32'h0);
    check_output("f1_irvalid_early", 32'(IR_VALID), 32'h0);
    IMEM_VALID = 1; IMEM_RDATA = 32'h8000_0003; tick(); IMEM_VALID = 0;
    check_output("f1_ir", IR, 32'h8000_0003);
    check_output("f1_opcode", 32'(OPCODE), 32'h8);
    check_output("f1_mm", 32'(MM), 32'h0);
    check_output("f1_irvalid", 32'(IR_VALID), 32'h1);
    check_output("f1_busy_done", 32'(BUSY), 32'h0);
    check_output("f1_req_done", 32'(IMEM_REQ), 32'h0);
    tick();
    check_output("f1_irvalid_pulse", 32'(IR_VALID), 32'h0);
    check_output("f1_busy_after", 32'(BUSY), 32'h0);

    // PC -> 1, then a fetch whose data arrives after 5 wait cycles
    PC_WRITE = 1; PC_SEL = 0; tick(); PC_WRITE = 0;
    check_output("inc_pc", 32'(PC), 32'h1);
    FETCH_EN = 1; tick(); FETCH_EN = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      check_output("f2_req_hold", 32'(IMEM_REQ), 32'h1);
      check_output("f2_addr_hold", 32'(IMEM_ADDR), 32'h1);
      if (IR_VALID) pulses++;
      FETCH_EN = (i == 1);
      PC_WRITE = (i == 2);
      tick();
    end
    FETCH_EN = 0; PC_WRITE = 0;
    check_output("f2_addr_after_pcw", 32'(IMEM_ADDR), 32'h1);
    check_output("f2_pc_midfetch", 32'(PC), 32'h2);
    IMEM_VALID = 1; IMEM_RDATA = 32'h1800_0010; tick(); IMEM_VALID = 0;
    check_output("f2_irvalid", 32'(IR_VALID), 32'h1);
    check_output("f2_opcode", 32'(OPCODE), 32'h1);
    check_output("f2_mm", 32'(MM), 32'h8);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (IR_VALID) pulses++;
    end
    check_output("f2_no_queued_fetch", 32'(pulses), 32'h0);
    check_output("f2_idle_busy", 32'(BUSY), 32'h0);

    // Absolute branch to IR[15:0]=0x0010
    PC_WRITE = 1; PC_SEL = 1; BR_SEL = 0; tick(); PC_WRITE = 0;
    check_output("abs_pc_10", 32'(PC), 32'h0010);
    FETCH_EN = 1; tick(); FETCH_EN = 0;
    check_output("f3_addr", 32'(IMEM_ADDR), 32'h0010);
    IMEM_VALID = 1; IMEM_RDATA = 32'h8000_FFFC; tick(); IMEM_VALID = 0;
    check_output("f3_ir", IR, 32'h8000_FFFC);
    PC_WRITE = 1; PC_SEL = 1; BR_SEL = 1; tick();
    check_output("rel_neg4", 32'(PC), 32'h000C);
    BR_SEL = 0; tick();
    check_output("abs_fffc", 32'(PC), 32'hFFFC);
    PC_SEL = 0; tick(); tick(); tick();
    check_output("inc_ffff", 32'(PC), 32'hFFFF);
    tick();
    check_output("inc_wrap", 32'(PC), 32'h0000);
    PC_SEL = 1; BR_SEL = 1; tick();
    check_output("rel_wrap", 32'(PC), 32'hFFFC);

    // PC_RST wins over PC_WRITE
    PC_SEL = 0; BR_SEL = 0; PC_RST = 1; tick(); PC_RST = 0; PC_WRITE = 0;
    check_output("pcrst_priority", 32'(PC), 32'h0000);

    // Halt capture and stickiness
    FETCH_EN = 1; tick(); FETCH_EN = 0;
    IMEM_VALID = 1; IMEM_RDATA = 32'hF000_0000; tick(); IMEM_VALID = 0;
    check_output("hlt_flag", 32'(HALTED), 32'h1);
    check_output("hlt_opcode", 32'(OPCODE), 32'hF);
    tick();
    FETCH_EN = 1; tick(); FETCH_EN = 0;
    check_output("hlt_no_req", 32'(IMEM_REQ), 32'h0);
    check_output("hlt_no_busy", 32'(BUSY), 32'h0);
    tick();
    check_output("hlt_no_req2", 32'(IMEM_REQ), 32'h0);
    PC_RST = 1; tick(); PC_RST = 0;
    check_output("hlt_survives_pcrst", 32'(HALTED), 32'h1);
    RST = 1; #1;
    check_output("hlt_async_clear", 32'(HALTED), 32'h0);
    check_output("rst_async_ir", IR, 32'h0);
    tick(); RST = 0; tick();

    // Reset aborts an in-flight fetch; a late valid is ignored
    FETCH_EN = 1; tick(); FETCH_EN = 0;
    check_output("abort_req_before", 32'(IMEM_REQ), 32'h1);
    RST = 1; #1;
    check_output("abort_req_async", 32'(IMEM_REQ), 32'h0);
    tick(); RST = 0;
    tick();
    IMEM_VALID = 1; IMEM_RDATA = 32'h1234_5678; tick(); IMEM_VALID = 0;
    check_output("abort_ir_kept", IR, 32'h0);
    check_output("abort_no_irvalid", 32'(IR_VALID), 32'h0);
    tick();
    check_output("abort_no_irvalid2", 32'(IR_VALID), 32'h0);
    check_output("abort_idle_req", 32'(IMEM_REQ), 32'h0);
    check_output("abort_idle_busy", 32'(BUSY), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
